// File: rtl/inc64_sequencer_pkg.sv
// inc64_sequencer_pkg: shared slice width, FSM encoding and all-ones slice constant
package inc64_sequencer_pkg;
  localparam int SLICE = 16;
  localparam logic [SLICE-1:0] SLICE_ONES = {SLICE{1'b1}};
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/inc64_sequencer_inc16.sv
// inc16: combinational 16-bit slice incrementer, wraps on all ones
module inc16
  import inc64_sequencer_pkg::*;
(
  input  logic [SLICE-1:0] a,
  output logic [SLICE-1:0] y
);
  assign y = a + 1'b1;
endmodule

// File: rtl/inc64_sequencer.sv
// inc64_sequencer: multi-cycle WIDTH-bit incrementer using one shared Inc16 slice, LSB slice first
module inc64_sequencer
  import inc64_sequencer_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             busy
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic carry_q, carry_d;
  logic [SLICE-1:0] s, s_inc;
  assign s = acc_q[idx_q*SLICE +: SLICE];
  inc16 u_inc (.a(s), .y(s_inc));
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    idx_d = idx_q;
    carry_d = carry_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        acc_d = in_data;
        idx_d = '0;
        state_d = RUN;
      end
      RUN: begin
        acc_d[idx_q*SLICE +: SLICE] = s_inc;
        // carry dies in this slice: upper slices are already final
        if (s != SLICE_ONES) begin
          carry_d = 1'b0;
          state_d = DONE;
        end else if (idx_q == IDXW'(NSLICE - 1)) begin
          carry_d = 1'b1;
          state_d = DONE;
        end else idx_d = idx_q + 1'b1;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      idx_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign out_data = acc_q;
  assign out_carry = carry_q;
endmodule
